// File: rtl/rvfi_mem_responder.sv
// Memory-side responder for the picorv32 native bus: bounded-latency handshake,
// byte-coherent shadow memory and sticky protocol checker. Define RVFI_MEM_FAIRNESS_EN to bound stalls.
module rvfi_mem_responder #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned ADDR_LSB = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               mem_valid,
    input  logic                               mem_instr,
    input  logic [XLEN-1:0]                    mem_addr,
    input  logic [XLEN-1:0]                    mem_wdata,
    input  logic [XLEN/8-1:0]                  mem_wstrb,
    output logic                               mem_ready,
    output logic [XLEN-1:0]                    mem_rdata,
    input  logic                               stall_req,
    input  logic [XLEN-1:0]                    rand_rdata,
    output logic                               protocol_err,
    output logic [$clog2(MAX_WAIT+1)-1:0]      stall_cnt
);

    localparam int unsigned NBYTES = XLEN / 8;
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [NBYTES-1:0] wstrb_q, wstrb_d;
    logic              instr_q, instr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [XLEN-1:0]   mem_q [DEPTH];
    logic [NBYTES-1:0] vld_q [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic              bus_changed;
    logic              wait_exit;

    assign idx         = addr_q[ADDR_LSB +: IDX_W];
    assign bus_changed = (addr_q != mem_addr) || (wdata_q != mem_wdata) ||
                         (wstrb_q != mem_wstrb) || (instr_q != mem_instr);

`ifdef RVFI_MEM_FAIRNESS_EN
    assign wait_exit = !stall_req || (cnt_q == CNT_W'(MAX_WAIT));
`else
    assign wait_exit = !stall_req;
`endif

    // Handshake FSM, request capture and registered response
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ready_d = 1'b0;
        rdata_d = '0;
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    instr_d = mem_instr;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                    if (mem_instr && (|mem_wstrb)) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!mem_valid) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    if (bus_changed) begin
                        err_d = 1'b1;
                    end
                    if (wait_exit) begin
                        state_d = S_ACK;
                        ready_d = 1'b1;
                        if (|wstrb_q) begin
                            rdata_d = rand_rdata;
                        end else begin
                            // Unwritten bytes fall back to harness-random data
                            for (int b = 0; b < int'(NBYTES); b++) begin
                                rdata_d[8*b +: 8] = vld_q[idx][b] ? mem_q[idx][8*b +: 8]
                                                                  : rand_rdata[8*b +: 8];
                            end
                        end
                    end else if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            instr_q <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Writes commit on the edge that leaves ACK, so reset in ACK abandons them
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                vld_q[i] <= '0;
            end
        end else if (state_q == S_ACK) begin
            vld_q[idx] <= vld_q[idx] | wstrb_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && (state_q == S_ACK)) begin
            for (int b = 0; b < int'(NBYTES); b++) begin
                if (wstrb_q[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

`ifdef RVFI_MEM_FAIRNESS_EN
    // Accepted requests must not wait more than MAX_WAIT+1 cycles for ready
    logic [CNT_W+1:0] run_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            run_q <= '0;
        end else if ((state_q == S_WAIT) && mem_valid && !mem_ready) begin
            run_q <= run_q + (CNT_W+2)'(1);
        end else begin
            run_q <= '0;
        end
    end

    fairness_a: assert property (@(posedge clock) disable iff (reset)
                                 run_q <= (CNT_W+2)'(MAX_WAIT + 1));
`endif

    assign mem_ready    = ready_q;
    assign mem_rdata    = rdata_q;
    assign protocol_err = err_q;
    assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_rvfi_mem_responder.sv
// Scoreboard bench for rvfi_mem_responder: expected responses queued at request
// time, checked by a monitor when mem_ready fires.
module tb_rvfi_mem_responder;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned MAX_WAIT = 3;
    localparam int unsigned ADDR_LSB = 2;
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             mem_valid = 1'b0;
    logic             mem_instr = 1'b0;
    logic [31:0]      mem_addr = '0;
    logic [31:0]      mem_wdata = '0;
    logic [3:0]       mem_wstrb = '0;
    logic             mem_ready;
    logic [31:0]      mem_rdata;
    logic             stall_req = 1'b0;
    logic [31:0]      rand_rdata = '0;
    logic             protocol_err;
    logic [CNT_W-1:0] stall_cnt;

    rvfi_mem_responder #(
        .XLEN(XLEN), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .ADDR_LSB(ADDR_LSB)
    ) dut (
        .clock(clock), .reset(reset),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall_req(stall_req), .rand_rdata(rand_rdata),
        .protocol_err(protocol_err), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        int          start;
        int          lat;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mdl_b [DEPTH][4];
    logic       mdl_v [DEPTH][4];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int word_idx(input logic [31:0] addr);
        return int'(addr[ADDR_LSB +: IDX_W]);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [31:0] rnd);
        logic [31:0] r;
        int idx;
        idx = word_idx(addr);
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = mdl_v[idx][b] ? mdl_b[idx][b] : rnd[8*b +: 8];
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) begin
            for (int b = 0; b < 4; b++) mdl_v[i][b] = 1'b0;
        end
    endtask

    // Response monitor: every ready pulse must match the oldest queued expectation
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (mem_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_ready", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_val({e.tag, "_rdata"}, 64'(mem_rdata), 64'(e.rdata));
                check_val({e.tag, "_latency"}, 64'(cyc - e.start), 64'(e.lat));
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        mem_valid = 1'b0;
        stall_req = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic instr, input logic [31:0] rnd,
                       input int stalls);
        exp_t e;
        int   eff;
        int   start;
        int   j;
        int   idx;
        bit   done;
        @(negedge clock);
        mem_valid  = 1'b1;
        mem_addr   = addr;
        mem_wdata  = wdata;
        mem_wstrb  = wstrb;
        mem_instr  = instr;
        rand_rdata = rnd;
        stall_req  = 1'b0;
        eff = stalls;
`ifdef RVFI_MEM_FAIRNESS_EN
        if (eff > int'(MAX_WAIT)) eff = int'(MAX_WAIT);
`endif
        start   = cyc;
        e.rdata = (wstrb != 4'h0) ? rnd : model_read(addr, rnd);
        e.start = start;
        e.lat   = 2 + eff;
        e.tag   = tag;
        exp_q.push_back(e);
        done = 1'b0;
        for (int k = 0; k < eff + 8 && !done; k++) begin
            @(posedge clock);
            #1;
            if (mem_ready === 1'b1) begin
                done = 1'b1;
            end else if (cyc - start >= 1) begin
                j = cyc - start - 1;
                if (stalls > 0) begin
                    check_val({tag, "_stall_cnt"}, 64'(stall_cnt),
                              64'((j < CNT_MAX) ? j : CNT_MAX));
                end
                stall_req = (j < stalls);
            end
        end
        if (!done) check_val({tag, "_timeout"}, 64'd0, 64'd1);
        mem_valid = 1'b0;
        stall_req = 1'b0;
        if (wstrb != 4'h0) begin
            idx = word_idx(addr);
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mdl_b[idx][b] = wdata[8*b +: 8];
                    mdl_v[idx][b] = 1'b1;
                end
            end
        end
        @(posedge clock);
        #1;
        check_val({tag, "_ready_one_cycle"}, 64'(mem_ready), 64'd0);
        check_val({tag, "_rdata_idle"}, 64'(mem_rdata), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        model_clear();
        do_reset();
        #1;
        check_val("rst_ready", 64'(mem_ready), 64'd0);
        check_val("rst_rdata", 64'(mem_rdata), 64'd0);
        check_val("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check_val("rst_err", 64'(protocol_err), 64'd0);

        txn("rd_08", 32'h8, 32'h0, 4'h0, 1'b0, 32'hA5A5A5A5, 0);
        check_val("rd_08_err", 64'(protocol_err), 64'd0);

        txn("wr_04", 32'h4, 32'h11223344, 4'hF, 1'b0, 32'h5555AAAA, 0);
        txn("rd_04", 32'h4, 32'h0, 4'h0, 1'b0, 32'h0, 0);
        txn("rd_44_alias", 32'h44, 32'h0, 4'h0, 1'b0, 32'h0, 0);
        txn("rd_46_unaligned", 32'h46, 32'h0, 4'h0, 1'b0, 32'h77777777, 0);

        txn("wr_0c_byte1", 32'hC, 32'h0000BB00, 4'h2, 1'b0, 32'h0, 0);
        txn("rd_0c", 32'hC, 32'h0, 4'h0, 1'b0, 32'hFFFFFFFF, 0);
        check_val("rd_0c_err", 64'(protocol_err), 64'd0);

        txn("wr_20_stall5", 32'h20, 32'h89ABCDEF, 4'hF, 1'b0, 32'h0, 5);
        txn("rd_20_stall2", 32'h20, 32'h0, 4'h0, 1'b0, 32'h12345678, 2);
        check_val("stall_err", 64'(protocol_err), 64'd0);

        // Abandon a write by dropping mem_valid in WAIT
        @(negedge clock);
        mem_valid = 1'b1; mem_addr = 32'h10; mem_wdata = 32'hDEADBEEF;
        mem_wstrb = 4'hF; mem_instr = 1'b0; stall_req = 1'b1;
        @(posedge clock); #1;
        mem_valid = 1'b0;
        @(posedge clock); #1;
        check_val("drop_err", 64'(protocol_err), 64'd1);
        check_val("drop_ready", 64'(mem_ready), 64'd0);
        stall_req = 1'b0;
        @(posedge clock); #1;
        check_val("drop_ready_after", 64'(mem_ready), 64'd0);
        txn("rd_10_after_drop", 32'h10, 32'h0, 4'h0, 1'b0, 32'h01020304, 0);
        check_val("drop_err_sticky", 64'(protocol_err), 64'd1);

        do_reset();
        #1;
        check_val("rst2_err", 64'(protocol_err), 64'd0);
        txn("rd_04_after_rst", 32'h4, 32'h0, 4'h0, 1'b0, 32'h0BADF00D, 0);

        // Reset arriving during WAIT of a write
        @(negedge clock);
        mem_valid = 1'b1; mem_addr = 32'h0; mem_wdata = 32'hCAFEF00D;
        mem_wstrb = 4'hF; mem_instr = 1'b0; stall_req = 1'b1;
        @(posedge clock); #1;
        reset = 1'b1; mem_valid = 1'b0; stall_req = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        check_val("rstwait_ready", 64'(mem_ready), 64'd0);
        check_val("rstwait_err", 64'(protocol_err), 64'd0);
        repeat (3) @(posedge clock);
        txn("rd_00_after_rstwait", 32'h0, 32'h0, 4'h0, 1'b0, 32'h13579BDF, 0);
        check_val("rstwait_err_after", 64'(protocol_err), 64'd0);

        txn("fetch_wr_14", 32'h14, 32'hA1B2C3D4, 4'hF, 1'b1, 32'h0, 0);
        check_val("fetch_wr_err", 64'(protocol_err), 64'd1);
        txn("fetch_rd_14", 32'h14, 32'h0, 4'h0, 1'b1, 32'hFFFFFFFF, 1);

        // Bus changes under a pending request: captured address still serves the read
        do_reset();
        txn("wr_08_pre", 32'h8, 32'h55667788, 4'hF, 1'b0, 32'h0, 0);
        check_val("pre_change_err", 64'(protocol_err), 64'd0);
        @(negedge clock);
        begin
            exp_t e;
            mem_valid = 1'b1; mem_addr = 32'h8; mem_wdata = 32'h0;
            mem_wstrb = 4'h0; mem_instr = 1'b0; stall_req = 1'b0; rand_rdata = 32'hFFFFFFFF;
            e.rdata = model_read(32'h8, 32'hFFFFFFFF);
            e.start = cyc;
            e.lat   = 2;
            e.tag   = "rd_08_changed";
            exp_q.push_back(e);
        end
        @(posedge clock); #1;
        mem_addr = 32'h18;
        @(posedge clock); #1;
        check_val("changed_ready", 64'(mem_ready), 64'd1);
        mem_valid = 1'b0;
        @(posedge clock); #1;
        check_val("changed_err", 64'(protocol_err), 64'd1);

        repeat (3) @(posedge clock);
        #2;
        check_val("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
